// File: rtl/do_serial_loader.sv
// Discrete-output loader: shifts a PIO word in MSB first, then loads, sets or clears bits of DO.
// Latency: DO is updated and DONE pulses two cycles after the cycle that carries the last data bit.
// Backpressure: none; SSHIFT gaps are simply waited out, and a WSTART mid-frame aborts the frame with FERR.
module do_serial_loader #(
    parameter int         WIDTH     = 26,
    parameter logic [8:0] ADDR_LOAD = 9'h106,
    parameter logic [8:0] ADDR_SET  = 9'h104,
    parameter logic [8:0] ADDR_CLR  = 9'h105
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic             WSTART,
    input  logic [8:0]       ADDR,
    input  logic             SBIT,
    input  logic             SSHIFT,
    input  logic             RESM,
    output logic [WIDTH-1:0] DO,
    output logic             BUSY,
    output logic             DONE,
    output logic             FERR
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_SET  = 2'd1,
        OP_CLR  = 2'd2
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] do_q, do_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;

    // Frame decode, bit shifting and DO update; RESM clear applied last so it wins over APPLY.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        do_d    = do_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Unknown addresses and stray SSHIFTs are dropped silently.
                if (WSTART) begin
                    if (ADDR == ADDR_LOAD) begin
                        op_d    = OP_LOAD;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end else if (ADDR == ADDR_SET) begin
                        op_d    = OP_SET;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end else if (ADDR == ADDR_CLR) begin
                        op_d    = OP_CLR;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                // A new WSTART mid-frame abandons the frame; any coincident bit is discarded
                // and the aborting strobe does not open another frame.
                if (WSTART) begin
                    ferr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (SSHIFT) begin
                    sr_d  = {sr_q[WIDTH-2:0], SBIT};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = ST_APPLY;
                    end
                end
            end

            ST_APPLY: begin
                case (op_q)
                    OP_LOAD: do_d = sr_q;
                    OP_SET:  do_d = do_q | sr_q;
                    OP_CLR:  do_d = do_q & ~sr_q;
                    default: do_d = do_q;
                endcase
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (RESM) begin
            do_d = '0;
        end
    end

    // State and datapath registers; SIM_RST dominates everything, including RESM and APPLY.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            sr_q    <= '0;
            cnt_q   <= '0;
            do_q    <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            do_q    <= do_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign DO   = do_q;
    assign BUSY = (state_q != ST_IDLE);
    assign DONE = done_q;
    assign FERR = ferr_q;

    // DONE comes only out of APPLY and FERR only out of SHIFT, so they can never coincide.
    a_done_ferr_excl: assert property (@(posedge SIM_CLK) disable iff (SIM_RST) !(DONE && FERR));

    // The bit counter never runs past a full word.
    a_cnt_range: assert property (@(posedge SIM_CLK) disable iff (SIM_RST) cnt_q <= CW'(WIDTH));

endmodule

// File: tb/tb_do_serial_loader.sv
// Bench for do_serial_loader: directed frames from the test plan, then random frames.
// Expected DONE/FERR pulses (cycle and DO value) are queued by the stimulus and
// consumed by a negedge monitor whenever the DUT raises DONE or FERR.
module tb_do_serial_loader;

    localparam int W = 26;
    localparam logic [8:0] A_LOAD = 9'h106;
    localparam logic [8:0] A_SET  = 9'h104;
    localparam logic [8:0] A_CLR  = 9'h105;

    logic         SIM_CLK = 1'b0;
    logic         SIM_RST = 1'b1;
    logic         WSTART  = 1'b0;
    logic [8:0]   ADDR    = '0;
    logic         SBIT    = 1'b0;
    logic         SSHIFT  = 1'b0;
    logic         RESM    = 1'b0;
    logic [W-1:0] DO;
    logic         BUSY;
    logic         DONE;
    logic         FERR;

    do_serial_loader #(
        .WIDTH(W), .ADDR_LOAD(A_LOAD), .ADDR_SET(A_SET), .ADDR_CLR(A_CLR)
    ) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .WSTART(WSTART), .ADDR(ADDR),
        .SBIT(SBIT), .SSHIFT(SSHIFT), .RESM(RESM),
        .DO(DO), .BUSY(BUSY), .DONE(DONE), .FERR(FERR)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    int cyc = 0;
    always @(posedge SIM_CLK) cyc <= cyc + 1;

    typedef struct {
        bit           is_done;
        logic [W-1:0] dov;
        int           at;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] model_do = '0;
    bit           gap_resm = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE/FERR cycle must match the next queued expectation.
    always @(negedge SIM_CLK) begin
        if (DONE || FERR) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, DONE, FERR}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind", {30'd0, DONE, FERR}, e.is_done ? 32'd2 : 32'd1);
                chk("pulse_cycle", 32'(cyc), 32'(e.at));
                chk("pulse_do", 32'(DO), 32'(e.dov));
            end
        end
    end

    function automatic bit is_valid(input logic [8:0] a);
        return (a == A_LOAD) || (a == A_SET) || (a == A_CLR);
    endfunction

    function automatic logic [W-1:0] apply_op(input logic [8:0] a, input logic [W-1:0] old,
                                              input logic [W-1:0] w);
        if (a == A_LOAD) return w;
        if (a == A_SET)  return old | w;
        return old & ~w;
    endfunction

    task automatic tick();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic start(input logic [8:0] a);
        WSTART = 1'b1;
        ADDR   = a;
        SSHIFT = 1'b0;
        tick();
        WSTART = 1'b0;
    endtask

    // Sends bits word[W-1] downward, n of them, with 0-3 idle cycles before each.
    task automatic shift_bits(input logic [W-1:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                SBIT = 1'($urandom);
                if (gap_resm && ($urandom_range(0, 7) == 0)) begin
                    RESM     = 1'b1;
                    model_do = '0;
                end
                tick();
                RESM = 1'b0;
            end
            SSHIFT = 1'b1;
            SBIT   = word[W-1-i];
            tick();
            SSHIFT = 1'b0;
        end
    endtask

    // One frame; abort_at >= 0 aborts after that many bits (valid address expected then).
    task automatic frame(input logic [8:0] a, input logic [W-1:0] word, input bit resm_apply,
                         input int abort_at, input bit abort_shift, input logic [8:0] abort_addr);
        bit v;
        int e;
        v = is_valid(a);
        start(a);
        chk("busy_start", 32'(BUSY), 32'(v));
        if (abort_at >= 0) begin
            shift_bits(word, abort_at);
            WSTART = 1'b1;
            ADDR   = abort_addr;
            SSHIFT = abort_shift;
            SBIT   = 1'($urandom);
            tick();
            WSTART = 1'b0;
            SSHIFT = 1'b0;
            if (v) q.push_back('{is_done: 1'b0, dov: model_do, at: cyc});
            chk("busy_after_abort", 32'(BUSY), 32'd0);
            tick();
            chk("do_after_abort", 32'(DO), 32'(model_do));
            return;
        end
        shift_bits(word, W);
        e = cyc;
        chk("busy_last_bit", 32'(BUSY), 32'(v));
        if (resm_apply) model_do = '0;
        else if (v)     model_do = apply_op(a, model_do, word);
        if (v) q.push_back('{is_done: 1'b1, dov: model_do, at: e + 1});
        RESM = resm_apply;
        if (v && ($urandom_range(0, 1) == 1)) begin
            // Strobes during APPLY must be ignored.
            WSTART = 1'b1;
            ADDR   = A_LOAD;
            SSHIFT = 1'b1;
        end
        tick();
        RESM   = 1'b0;
        WSTART = 1'b0;
        SSHIFT = 1'b0;
        chk("busy_end", 32'(BUSY), 32'd0);
        chk("do_after_frame", 32'(DO), 32'(model_do));
    endtask

    initial begin
        // Reset then idle.
        tick();
        tick();
        SIM_RST = 1'b0;
        chk("rst_do", 32'(DO), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_ferr", 32'(FERR), 32'd0);
        shift_bits(26'h3FFFFFF, 10);
        chk("idle_shift_do", 32'(DO), 32'd0);
        chk("idle_shift_busy", 32'(BUSY), 32'd0);

        // Full load.
        frame(A_LOAD, 26'h2AAAAAA, 1'b0, -1, 1'b0, 9'h0);
        chk("load_do", 32'(DO), 32'h2AAAAAA);

        // Set / clear sequence.
        frame(A_LOAD, 26'h00000F0, 1'b0, -1, 1'b0, 9'h0);
        frame(A_SET, 26'h0000003, 1'b0, -1, 1'b0, 9'h0);
        chk("set_do", 32'(DO), 32'h00000F3);
        frame(A_CLR, 26'h0000030, 1'b0, -1, 1'b0, 9'h0);
        chk("clr_do", 32'(DO), 32'h00000C3);

        // Abort after 12 bits with a coincident SSHIFT, then a fresh load.
        frame(A_LOAD, 26'h3FFFFFF, 1'b0, 12, 1'b1, A_LOAD);
        chk("abort_do", 32'(DO), 32'h00000C3);
        frame(A_LOAD, 26'h0000001, 1'b0, -1, 1'b0, 9'h0);
        chk("fresh_do", 32'(DO), 32'h0000001);

        // Address filter and RESM in APPLY.
        frame(9'h107, 26'h155AA55, 1'b0, -1, 1'b0, 9'h0);
        chk("filter_do", 32'(DO), 32'h0000001);
        frame(A_LOAD, 26'h1234567, 1'b1, -1, 1'b0, 9'h0);
        chk("resm_do", 32'(DO), 32'd0);

        // Reset mid-frame.
        start(A_LOAD);
        shift_bits(26'h3FFFFFF, 20);
        SIM_RST = 1'b1;
        tick();
        tick();
        SIM_RST  = 1'b0;
        model_do = '0;
        chk("midrst_do", 32'(DO), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        chk("midrst_done", 32'(DONE), 32'd0);
        chk("midrst_ferr", 32'(FERR), 32'd0);
        frame(A_LOAD, 26'h0ABCDEF, 1'b0, -1, 1'b0, 9'h0);
        chk("midrst_load", 32'(DO), 32'h0ABCDEF);

        // Random frames, aborts and RESM pulses.
        gap_resm = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [8:0]   a;
            logic [W-1:0] w;
            int           sel;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: a = A_LOAD;
                3, 4:    a = A_SET;
                5, 6:    a = A_CLR;
                default: a = 9'($urandom_range(0, 511));
            endcase
            w = W'($urandom);
            if (is_valid(a) && ($urandom_range(0, 4) == 0)) begin
                frame(a, w, 1'b0, int'($urandom_range(0, W - 1)), 1'($urandom),
                      9'($urandom_range(256, 263)));
            end else begin
                frame(a, w, ($urandom_range(0, 5) == 0), -1, 1'b0, 9'h0);
            end
        end
        gap_resm = 1'b0;

        tick();
        tick();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
